// File: rtl/thermo_stim_if.sv
// Stimulus bundle between the thermometer ramp generator and its user.
// toggle_cnt exists only when THERMO_STIM_TOGGLE_CNT_EN is defined.
interface thermo_stim_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] bits;
    logic             exp_o;
    logic             busy;
    logic             done;
`ifdef THERMO_STIM_TOGGLE_CNT_EN
    logic [15:0]      toggle_cnt;

    modport master (output start, abort, input bits, exp_o, busy, done, toggle_cnt);
    modport slave  (input start, abort, output bits, exp_o, busy, done, toggle_cnt);
`else
    modport master (output start, abort, input bits, exp_o, busy, done);
    modport slave  (input start, abort, output bits, exp_o, busy, done);
`endif
endinterface

// File: rtl/thermo_stim.sv
// Thermometer-code ramp generator for a downstream AND-reduction stage.
// Optional feature macro: THERMO_STIM_TOGGLE_CNT_EN (adds saturating toggle_cnt).
module thermo_stim #(
    parameter int WIDTH       = 4,
    parameter int STEP_CYCLES = 1,
    parameter int HOLD_CYCLES = 10
) (
    input  logic          clk,
    input  logic          rst,
    thermo_stim_if.slave  sif
);
    // state | meaning
    // IDLE  | bits cleared, waiting for start
    // RAMP  | one more bit set every STEP_CYCLES cycles, LSB first
    // HOLD  | all ones held for HOLD_CYCLES cycles, then clear and pulse done
    typedef enum logic [1:0] {IDLE, RAMP, HOLD} state_t;

    localparam int              SW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0]     STEP_LAST = 16'(STEP_CYCLES - 1);
    localparam logic [15:0]     HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0]   STEP_MAX  = SW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic [SW-1:0]    step_q, step_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                bits_d = '0;
                // abort outranks start so a simultaneous request never launches
                if (!sif.abort && sif.start) begin
                    state_d = RAMP;
                    step_d  = '0;
                    cnt_d   = '0;
                end
            end
            RAMP: begin
                if (sif.abort) begin
                    state_d = IDLE;
                    bits_d  = '0;
                    step_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d          = '0;
                    bits_d[step_q] = 1'b1;
                    if (step_q == STEP_MAX) begin
                        state_d = HOLD;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (sif.abort) begin
                    state_d = IDLE;
                    bits_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    bits_d  = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                bits_d  = '0;
                step_d  = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bits_q  <= '0;
            step_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sif.bits  = bits_q;
    assign sif.exp_o = &bits_q;
    assign sif.busy  = busy_q;
    assign sif.done  = done_q;

`ifdef THERMO_STIM_TOGGLE_CNT_EN
    logic        start_acc;
    logic [4:0]  flips;
    logic [16:0] tog_sum;
    logic [15:0] tog_q, tog_d;

    assign start_acc = (state_q == IDLE) && sif.start && !sif.abort;

    always_comb begin
        flips   = 5'($countones(bits_d ^ bits_q));
        tog_sum = {1'b0, tog_q} + {12'd0, flips};
        tog_d   = tog_sum[16] ? 16'hFFFF : tog_sum[15:0];
        if (start_acc) tog_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) tog_q <= '0;
        else     tog_q <= tog_d;
    end

    assign sif.toggle_cnt = tog_q;
`endif
endmodule

// File: tb/tb_thermo_stim.sv
// Directed bench for thermo_stim: expected per-edge outputs queued on a scoreboard
// from a closed-form timing model, popped and compared one edge at a time.
module tb_thermo_stim;
    typedef struct packed {
        logic [3:0] bits;
        logic       busy;
        logic       done;
        logic       exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    thermo_stim_if #(.WIDTH(4)) if1 ();
    thermo_stim_if #(.WIDTH(4)) if2 ();

    thermo_stim #(.WIDTH(4), .STEP_CYCLES(1), .HOLD_CYCLES(10)) dut1 (
        .clk (clk),
        .rst (rst),
        .sif (if1)
    );

    thermo_stim #(.WIDTH(4), .STEP_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .sif (if2)
    );

    always #5 clk = ~clk;

    // expected outputs k edges after the start edge (k=0), WIDTH 4
    function automatic exp_t calc(input int k, input int s, input int h);
        exp_t e;
        int   fin;
        int   ones;
        e   = '0;
        fin = 4 * s + h;
        if (k < 0 || k > fin) return e;
        if (k == fin) begin
            e.done = 1'b1;
            return e;
        end
        ones   = k / s;
        if (ones > 4) ones = 4;
        e.bits = 4'((1 << ones) - 1);
        e.busy = 1'b1;
        e.exp  = (ones == 4);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input int k, input logic [3:0] b,
                       input logic bsy, input logic dn, input logic ex);
        exp_t e;
        exp_t o;
        o = {b, bsy, dn, ex};
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s edge=%0d scoreboard empty, observed=%h", tag, k, o);
            return;
        end
        e = sb.pop_front();
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s edge=%0d observed bits/busy/done/exp=%b required=%b", tag, k, o, e);
        end
    endtask

    task automatic cmp16(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d required=%0d", tag, o, e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.push_back('0);
        cmp("reset", 0, if1.bits, if1.busy, if1.done, if1.exp_o);
    endtask

    initial begin
        if1.start = 1'b0; if1.abort = 1'b0;
        if2.start = 1'b0; if2.abort = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.push_back('0);
        cmp("reset_state", 0, if1.bits, if1.busy, if1.done, if1.exp_o);
`ifdef THERMO_STIM_TOGGLE_CNT_EN
        cmp16("toggle_reset", if1.toggle_cnt, 16'd0);
`endif

        // default sequence
        for (int k = 0; k <= 16; k++) sb.push_back(calc(k, 1, 10));
        if1.start = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            if (k == 0) if1.start = 1'b0;
            cmp("seq_default", k, if1.bits, if1.busy, if1.done, if1.exp_o);
        end
`ifdef THERMO_STIM_TOGGLE_CNT_EN
        cmp16("toggle_one_seq", if1.toggle_cnt, 16'd8);
`endif

        // slow step, short hold
        for (int k = 0; k <= 15; k++) sb.push_back(calc(k, 3, 2));
        if2.start = 1'b1;
        for (int k = 0; k <= 15; k++) begin
            tick();
            if (k == 0) if2.start = 1'b0;
            cmp("seq_step3_hold2", k, if2.bits, if2.busy, if2.done, if2.exp_o);
        end

        // abort in HOLD at edge 6, restart at edge 8
        for (int k = 0; k <= 10; k++)
            sb.push_back((k < 6) ? calc(k, 1, 10) : (k < 8) ? exp_t'('0) : calc(k - 8, 1, 10));
        if1.start = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 0) if1.start = 1'b0;
            if (k == 5) if1.abort = 1'b1;
            if (k == 6) if1.abort = 1'b0;
            if (k == 7) if1.start = 1'b1;
            if (k == 8) if1.start = 1'b0;
            cmp("abort_hold", k, if1.bits, if1.busy, if1.done, if1.exp_o);
        end
        do_reset();
`ifdef THERMO_STIM_TOGGLE_CNT_EN
        cmp16("toggle_after_rst", if1.toggle_cnt, 16'd0);
`endif

        // start held high: ignored on the done edge, accepted the edge after
        for (int k = 0; k <= 16; k++)
            sb.push_back((k <= 14) ? calc(k, 1, 10) : calc(k - 15, 1, 10));
        if1.start = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            cmp("start_held", k, if1.bits, if1.busy, if1.done, if1.exp_o);
        end
        if1.start = 1'b0;
        do_reset();

        // reset mid-ramp with start still high
        sb.push_back(calc(0, 1, 10));
        sb.push_back(calc(1, 1, 10));
        sb.push_back('0);
        sb.push_back('0);
        if1.start = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            tick();
            if (k == 1) rst = 1'b1;
            if (k == 2) begin
                rst       = 1'b0;
                if1.start = 1'b0;
            end
            cmp("rst_mid_ramp", k, if1.bits, if1.busy, if1.done, if1.exp_o);
        end

        // abort and start together in IDLE
        sb.push_back('0);
        sb.push_back('0);
        if1.start = 1'b1;
        if1.abort = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            tick();
            if (k == 0) begin
                if1.start = 1'b0;
                if1.abort = 1'b0;
            end
            cmp("abort_start_idle", k, if1.bits, if1.busy, if1.done, if1.exp_o);
        end

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_leftover entries=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
